// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master round-robin arbiter for the DMemory_IO data port (optional DMEM_ARB_LOCK_EN)
module dmem_arbiter #(
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic          clock,
  input  logic          reset,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] draddr,
  output logic [DW-1:0] dwdata,
  output logic          dwrite,
  output logic          dread,
  input  logic [DW-1:0] drdata
);

  // A lock limit below one would make locked re-grants impossible to express.
  if (MAX_LOCK < 1) begin : g_bad_max_lock
    $error("dmem_arbiter: MAX_LOCK must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          elig0, elig1;

`ifdef DMEM_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_go0, lock_go1;
`endif

  // Next-state, ack, read-data capture and last-served pointer.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    // A master still showing its ack has not yet dropped the served request.
    elig0      = m0_req & ~m0_ack_q;
    elig1      = m1_req & ~m1_ack_q;
`ifdef DMEM_ARB_LOCK_EN
    cnt_d      = cnt_q;
    lock_go0   = m0_ack_q & m0_lock & m0_req & (cnt_q < CW'(MAX_LOCK));
    lock_go1   = m1_ack_q & m1_lock & m1_req & (cnt_q < CW'(MAX_LOCK));
`endif
    case (state_q)
      IDLE: begin
`ifdef DMEM_ARB_LOCK_EN
        // The locking run ends as soon as its owner lets go of req.
        if (last_q ? !m1_req : !m0_req) cnt_d = '0;
        if (lock_go0) state_d = GNT0;
        else if (lock_go1) state_d = GNT1;
        else
`endif
        if (elig0 && elig1) state_d = last_q ? GNT0 : GNT1;
        else if (elig0) state_d = GNT0;
        else if (elig1) state_d = GNT1;
      end
      GNT0: begin
        m0_ack_d = 1'b1;
        if (!m0_we) m0_rdata_d = drdata;
        last_d   = 1'b0;
        state_d  = IDLE;
`ifdef DMEM_ARB_LOCK_EN
        if (!last_q) cnt_d = (cnt_q < CW'(MAX_LOCK)) ? cnt_q + CW'(1) : cnt_q;
        else cnt_d = CW'(1);
`endif
      end
      GNT1: begin
        m1_ack_d = 1'b1;
        if (!m1_we) m1_rdata_d = drdata;
        last_d   = 1'b1;
        state_d  = IDLE;
`ifdef DMEM_ARB_LOCK_EN
        if (last_q) cnt_d = (cnt_q < CW'(MAX_LOCK)) ? cnt_q + CW'(1) : cnt_q;
        else cnt_d = CW'(1);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Single state register for the FSM and its registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
`ifdef DMEM_ARB_LOCK_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
`ifdef DMEM_ARB_LOCK_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Memory port mux: the granted master drives the port for its one grant cycle.
  always_comb begin
    draddr = '0;
    dwdata = '0;
    dwrite = 1'b0;
    dread  = 1'b0;
    case (state_q)
      GNT0: begin
        draddr = m0_addr;
        dwdata = m0_wdata;
        dwrite = m0_we;
        dread  = ~m0_we;
      end
      GNT1: begin
        draddr = m1_addr;
        dwdata = m1_wdata;
        dwrite = m1_we;
        dread  = ~m1_we;
      end
      default: ;
    endcase
  end

  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule
